lsu_bank_ctrl: RTL and testbench

//  Parametrised successor of the even/odd byte-bank store decoder; owns the data-memory port of the LSU.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_lane_map.sv | 18 +
 rtl/lsu_bank_ctrl.sv | 159 +++++++++++++++
 tb/tb_lsu_bank_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU data-memory bank controller.
package lsu_pkg;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_W3 = 2'd3} lsu_size_e;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_e;

  function automatic logic [2:0] size_bytes(lsu_size_e s);
    case (s)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] ld_extend(logic [31:0] d, lsu_size_e s, logic uns);
    case (s)
      SZ_B:    return {{24{d[7] & ~uns}}, d[7:0]};
      SZ_H:    return {{16{d[15] & ~uns}}, d[15:0]};
      default: return d;
    endcase
  endfunction
endpackage

// File: rtl/lsu_lane_map.sv
// Maps access byte j of address addr onto its bank index and bank row.
module lsu_lane_map #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_AW   = 13,
  localparam int LB       = $clog2(NUM_BANKS)
) (
  input  logic [LB+BANK_AW-1:0] addr,
  input  logic [3:0]            j,
  output logic [LB-1:0]         bank,
  output logic [BANK_AW-1:0]    row
);
  logic [LB+BANK_AW-1:0] ba;

  // Sum is truncated to the bank address space so the row wraps to 0.
  assign ba   = addr + (LB+BANK_AW)'(j);
  assign bank = ba[LB-1:0];
  assign row  = ba[LB+BANK_AW-1:LB];
endmodule

// File: rtl/lsu_bank_ctrl.sv
// LSU data-memory port: splits loads/stores into byte-lane beats over NUM_BANKS banks.
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests trap instead of executing byte-split.
module lsu_bank_ctrl
  import lsu_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int BANK_AW   = 13
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_req_valid,
  output logic                           o_req_ready,
  input  logic [31:0]                    i_req_addr,
  input  logic                           i_req_wren,
  input  logic [1:0]                     i_req_size,
  input  logic                           i_req_unsigned,
  input  logic [31:0]                    i_st_data,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic [31:0]                    o_ld_data,
  output logic                           o_misaligned,
  output logic [NUM_BANKS*BANK_AW-1:0]   o_bank_addr,
  output logic [NUM_BANKS*8-1:0]         o_bank_wdata,
  output logic [NUM_BANKS-1:0]           o_bank_we,
  input  logic [NUM_BANKS*8-1:0]         i_bank_rdata
);
  localparam int LB = $clog2(NUM_BANKS);
  localparam int AW = LB + BANK_AW;

  lsu_state_e    state;
  logic [AW-1:0] r_addr;
  lsu_size_e     r_size;
  logic          r_wren, r_uns;
  logic [31:0]   r_wdata, ld_buf, ld_merge, ld_q;
  logic          beat;
  logic [2:0]    bytes;
  logic [4:0]    beat_end;
  logic          last_beat, issue_act;

  logic [NUM_BANKS-1:0][LB-1:0]      l_bank, cap_bank;
  logic [NUM_BANKS-1:0][BANK_AW-1:0] l_row, bank_addr;
  logic [NUM_BANKS-1:0][3:0]         l_j;
  logic [NUM_BANKS-1:0][1:0]         l_byte, cap_byte;
  logic [NUM_BANKS-1:0]              l_drv, cap_vld, bank_we;
  logic [NUM_BANKS-1:0][7:0]         bank_wdata, bank_rdata;
  logic                              unused_addr;

  assign unused_addr = ^i_req_addr[31:AW];
  assign bank_rdata  = i_bank_rdata;
  assign bytes       = size_bytes(r_size);
  assign beat_end    = 5'(beat) * 5'(NUM_BANKS) + 5'(NUM_BANKS);
  assign last_beat   = beat_end >= 5'(bytes);
  assign issue_act   = (state == ISSUE) && !i_reset;

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_lane
    assign l_j[i]    = 4'(beat) * 4'(NUM_BANKS) + 4'(i);
    assign l_byte[i] = l_j[i][1:0];
    assign l_drv[i]  = issue_act && (l_j[i] < {1'b0, bytes});
    lsu_lane_map #(.NUM_BANKS(NUM_BANKS), .BANK_AW(BANK_AW)) u_map (
      .addr (r_addr),
      .j    (l_j[i]),
      .bank (l_bank[i]),
      .row  (l_row[i])
    );
  end

  // Lanes within a beat always land on distinct banks, so this crossbar never collides.
  always_comb begin
    bank_addr  = '0;
    bank_wdata = '0;
    bank_we    = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (l_drv[i]) begin
        bank_addr[l_bank[i]] = l_row[i];
        if (r_wren) begin
          bank_we[l_bank[i]]    = 1'b1;
          bank_wdata[l_bank[i]] = r_wdata[{l_byte[i], 3'b000} +: 8];
        end
      end
    end
  end

  always_comb begin
    ld_merge = ld_buf;
    for (int i = 0; i < NUM_BANKS; i++)
      if (cap_vld[i]) ld_merge[{cap_byte[i], 3'b000} +: 8] = bank_rdata[cap_bank[i]];
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic is_misal, misal_q;
  assign is_misal = (i_req_size == 2'd1) ? i_req_addr[0] :
                    (i_req_size[1] ? |i_req_addr[1:0] : 1'b0);
  assign o_misaligned = misal_q;
`else
  assign o_misaligned = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      r_addr   <= '0;
      r_size   <= SZ_B;
      r_wren   <= 1'b0;
      r_uns    <= 1'b0;
      r_wdata  <= '0;
      beat     <= 1'b0;
      cap_vld  <= '0;
      cap_bank <= '0;
      cap_byte <= '0;
      ld_buf   <= '0;
      ld_q     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misal_q  <= 1'b0;
`endif
    end else begin
      ld_buf  <= ld_merge;
      cap_vld <= '0;
      case (state)
        IDLE: if (i_req_valid) begin
          r_addr  <= i_req_addr[AW-1:0];
          r_size  <= lsu_size_e'(i_req_size);
          r_wren  <= i_req_wren;
          r_uns   <= i_req_unsigned;
          r_wdata <= i_st_data;
          beat    <= 1'b0;
          ld_buf  <= '0;
          ld_q    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
          misal_q <= is_misal;
          state   <= is_misal ? RESP : ISSUE;
`else
          state   <= ISSUE;
`endif
        end
        ISSUE: begin
          // Remember which lanes were read so next cycle's bank data lands in the right bytes.
          cap_vld  <= r_wren ? '0 : l_drv;
          cap_bank <= l_bank;
          cap_byte <= l_byte;
          if (last_beat) state <= r_wren ? RESP : WAIT;
          else           beat  <= beat + 1'b1;
        end
        WAIT: begin
          ld_q  <= ld_extend(ld_merge, r_size, r_uns);
          state <= RESP;
        end
        RESP: if (i_rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_req_ready  = (state == IDLE) && !i_reset;
  assign o_rsp_valid  = (state == RESP);
  assign o_ld_data    = ld_q;
  assign o_bank_addr  = bank_addr;
  assign o_bank_wdata = bank_wdata;
  assign o_bank_we    = bank_we;
endmodule

// File: tb/tb_lsu_bank_ctrl.sv
// Directed bench: a 4-bank and a 2-bank controller driven with hand-computed vectors.
module tb_lsu_bank_ctrl;
  logic clk;
  int n_cmp = 0;
  int n_err = 0;

  logic        f_rst, f_req_valid, f_req_ready, f_req_wren, f_req_unsigned;
  logic [31:0] f_req_addr, f_st_data, f_ld_data, f_bank_wdata, f_bank_rdata;
  logic [1:0]  f_req_size;
  logic        f_rsp_valid, f_rsp_ready, f_misaligned;
  logic [51:0] f_bank_addr;
  logic [3:0]  f_bank_we;

  logic        t_rst, t_req_valid, t_req_ready, t_req_wren, t_req_unsigned;
  logic [31:0] t_req_addr, t_st_data, t_ld_data;
  logic [15:0] t_bank_wdata, t_bank_rdata;
  logic [1:0]  t_req_size;
  logic        t_rsp_valid, t_rsp_ready, t_misaligned;
  logic [25:0] t_bank_addr;
  logic [1:0]  t_bank_we;

  lsu_bank_ctrl #(.NUM_BANKS(4), .BANK_AW(13)) u_f (
    .i_clk(clk), .i_reset(f_rst), .i_req_valid(f_req_valid), .o_req_ready(f_req_ready),
    .i_req_addr(f_req_addr), .i_req_wren(f_req_wren), .i_req_size(f_req_size),
    .i_req_unsigned(f_req_unsigned), .i_st_data(f_st_data), .o_rsp_valid(f_rsp_valid),
    .i_rsp_ready(f_rsp_ready), .o_ld_data(f_ld_data), .o_misaligned(f_misaligned),
    .o_bank_addr(f_bank_addr), .o_bank_wdata(f_bank_wdata), .o_bank_we(f_bank_we),
    .i_bank_rdata(f_bank_rdata));

  lsu_bank_ctrl #(.NUM_BANKS(2), .BANK_AW(13)) u_t (
    .i_clk(clk), .i_reset(t_rst), .i_req_valid(t_req_valid), .o_req_ready(t_req_ready),
    .i_req_addr(t_req_addr), .i_req_wren(t_req_wren), .i_req_size(t_req_size),
    .i_req_unsigned(t_req_unsigned), .i_st_data(t_st_data), .o_rsp_valid(t_rsp_valid),
    .i_rsp_ready(t_rsp_ready), .o_ld_data(t_ld_data), .o_misaligned(t_misaligned),
    .o_bank_addr(t_bank_addr), .o_bank_wdata(t_bank_wdata), .o_bank_we(t_bank_we),
    .i_bank_rdata(t_bank_rdata));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Aligned-or-split word store on the 4-bank unit; response expected in cycle 2.
  task automatic f_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] we, input logic [51:0] ba, input logic [31:0] wd);
    f_req_valid = 1'b1; f_req_addr = addr; f_req_wren = 1'b1; f_req_size = 2'd2;
    f_st_data = data; #1;
    chk({tag, ".rdy"}, 64'(f_req_ready), 64'd1);
    chk({tag, ".idle_we"}, 64'(f_bank_we), 64'd0);
    step(); f_req_valid = 1'b0; #1;
    chk({tag, ".we"}, 64'(f_bank_we), 64'(we));
    chk({tag, ".addr"}, 64'(f_bank_addr), 64'(ba));
    chk({tag, ".wdata"}, 64'(f_bank_wdata), 64'(wd));
    chk({tag, ".c1_rsp"}, 64'(f_rsp_valid), 64'd0);
    step(); #1;
    chk({tag, ".rsp"}, 64'(f_rsp_valid), 64'd1);
    chk({tag, ".ld0"}, 64'(f_ld_data), 64'd0);
    chk({tag, ".mis"}, 64'(f_misaligned), 64'd0);
    chk({tag, ".resp_we"}, 64'(f_bank_we), 64'd0);
    step(); #1;
    chk({tag, ".back_idle"}, 64'(f_rsp_valid), 64'd0);
  endtask

  // Single-beat load on the 4-bank unit; bank bytes presented in WAIT, response in cycle 3.
  task automatic f_load(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] rd, input logic [31:0] exp);
    f_req_valid = 1'b1; f_req_addr = addr; f_req_wren = 1'b0; f_req_size = sz;
    f_req_unsigned = uns; #1;
    chk({tag, ".rdy"}, 64'(f_req_ready), 64'd1);
    step(); f_req_valid = 1'b0; #1;
    chk({tag, ".ld_we"}, 64'(f_bank_we), 64'd0);
    step(); f_bank_rdata = rd; #1;
    chk({tag, ".wait_rsp"}, 64'(f_rsp_valid), 64'd0);
    step(); f_bank_rdata = '0; #1;
    chk({tag, ".rsp"}, 64'(f_rsp_valid), 64'd1);
    chk({tag, ".data"}, 64'(f_ld_data), 64'(exp));
    step(); #1;
  endtask

  initial begin
    f_rst = 1'b1; f_req_valid = 1'b0; f_req_addr = '0; f_req_wren = 1'b0; f_req_size = '0;
    f_req_unsigned = 1'b0; f_st_data = '0; f_rsp_ready = 1'b1; f_bank_rdata = '0;
    t_rst = 1'b1; t_req_valid = 1'b0; t_req_addr = '0; t_req_wren = 1'b0; t_req_size = '0;
    t_req_unsigned = 1'b0; t_st_data = '0; t_rsp_ready = 1'b1; t_bank_rdata = '0;

    step(); step(); #1;
    chk("rst.rsp_valid", 64'(f_rsp_valid), 64'd0);
    chk("rst.req_ready", 64'(f_req_ready), 64'd0);
    chk("rst.we", 64'(f_bank_we), 64'd0);
    chk("rst.addr", 64'(f_bank_addr), 64'd0);
    chk("rst.wdata", 64'(f_bank_wdata), 64'd0);
    chk("rst.ld", 64'(f_ld_data), 64'd0);
    chk("rst.mis", 64'(f_misaligned), 64'd0);
    chk("rst.t_ready", 64'(t_req_ready), 64'd0);
    f_rst = 1'b0; t_rst = 1'b0; #1;
    chk("rst.rel_ready", 64'(f_req_ready), 64'd1);
    chk("rst.t_rel_ready", 64'(t_req_ready), 64'd1);

    // NB=4 sw 0x6: banks2/3 row1 DD/CC, banks0/1 row2 BB/AA
    f_store("sw6", 32'h6, 32'hAABBCCDD, 4'hF, {13'd1, 13'd1, 13'd2, 13'd2}, 32'hCCDDAABB);

    // NB=4 sw 0x7FFE: row wraps from 0x1FFF to 0
    f_store("wrap", 32'h7FFE, 32'h44332211, 4'hF, {13'h1FFF, 13'h1FFF, 13'h0, 13'h0}, 32'h22114433);

    // NB=4 loads with sign/zero extension
    f_load("lh1", 32'h1, 2'd1, 1'b0, 32'h00800100, 32'hFFFF8001);
    f_load("lhu1", 32'h1, 2'd1, 1'b1, 32'h00800100, 32'h00008001);
    f_load("lbu3", 32'h3, 2'd0, 1'b1, 32'hF0000000, 32'h000000F0);
    f_load("lb3", 32'h3, 2'd0, 1'b0, 32'hF0000000, 32'hFFFFFFF0);
    f_load("lw10", 32'h10, 2'd2, 1'b0, 32'h8899AABB, 32'h8899AABB);

    // Misaligned word store
`ifdef LSU_MISALIGN_TRAP_EN
    f_req_valid = 1'b1; f_req_addr = 32'h3; f_req_wren = 1'b1; f_req_size = 2'd2;
    f_st_data = 32'h44332211; #1;
    chk("mis.rdy", 64'(f_req_ready), 64'd1);
    step(); f_req_valid = 1'b0; #1;
    chk("mis.rsp", 64'(f_rsp_valid), 64'd1);
    chk("mis.flag", 64'(f_misaligned), 64'd1);
    chk("mis.we", 64'(f_bank_we), 64'd0);
    chk("mis.ld", 64'(f_ld_data), 64'd0);
    step(); #1;
    chk("mis.idle", 64'(f_rsp_valid), 64'd0);
`else
    f_store("mis3", 32'h3, 32'h44332211, 4'hF, {13'd0, 13'd1, 13'd1, 13'd1}, 32'h11443322);
`endif

    // NB=2 lw 0x4: two beats, rows 2 then 3
    t_req_valid = 1'b1; t_req_addr = 32'h4; t_req_wren = 1'b0; t_req_size = 2'd2;
    t_req_unsigned = 1'b0; #1;
    chk("lw2.rdy", 64'(t_req_ready), 64'd1);
    step(); t_req_valid = 1'b0; #1;
    chk("lw2.b0_addr", 64'(t_bank_addr), 64'({13'd2, 13'd2}));
    chk("lw2.b0_we", 64'(t_bank_we), 64'd0);
    step(); t_bank_rdata = 16'h8001; #1;
    chk("lw2.b1_addr", 64'(t_bank_addr), 64'({13'd3, 13'd3}));
    chk("lw2.c2_rsp", 64'(t_rsp_valid), 64'd0);
    step(); t_bank_rdata = 16'h127F; #1;
    chk("lw2.c3_rsp", 64'(t_rsp_valid), 64'd0);
    chk("lw2.wait_we", 64'(t_bank_we), 64'd0);
    step(); t_bank_rdata = '0; #1;
    chk("lw2.rsp", 64'(t_rsp_valid), 64'd1);
    chk("lw2.data", 64'(t_ld_data), 64'h127F8001);
    step(); #1;
    chk("lw2.idle", 64'(t_req_ready), 64'd1);

    // NB=2 sw with reset in the first ISSUE cycle: second beat must never write
    t_req_valid = 1'b1; t_req_addr = 32'h8; t_req_wren = 1'b1; t_req_size = 2'd2;
    t_st_data = 32'h44332211; #1;
    step(); t_req_valid = 1'b0; t_rst = 1'b1; #1;
    chk("rstmid.ready", 64'(t_req_ready), 64'd0);
    step(); t_rst = 1'b0; #1;
    chk("rstmid.we", 64'(t_bank_we), 64'd0);
    chk("rstmid.rsp", 64'(t_rsp_valid), 64'd0);
    chk("rstmid.idle", 64'(t_req_ready), 64'd1);
    step(); #1;
    chk("rstmid.we2", 64'(t_bank_we), 64'd0);

    // NB=2 sw held in RESP for 3 cycles by i_rsp_ready=0
    t_rsp_ready = 1'b0;
    t_req_valid = 1'b1; #1;
    step(); t_req_valid = 1'b0; #1;
    chk("hold.b0_we", 64'(t_bank_we), 64'd3);
    chk("hold.b0_addr", 64'(t_bank_addr), 64'({13'd4, 13'd4}));
    chk("hold.b0_wd", 64'(t_bank_wdata), 64'h2211);
    step(); #1;
    chk("hold.b1_we", 64'(t_bank_we), 64'd3);
    chk("hold.b1_addr", 64'(t_bank_addr), 64'({13'd5, 13'd5}));
    chk("hold.b1_wd", 64'(t_bank_wdata), 64'h4433);
    step(); #1;
    chk("hold.rsp1", 64'(t_rsp_valid), 64'd1);
    step(); #1;
    chk("hold.rsp2", 64'(t_rsp_valid), 64'd1);
    chk("hold.noready", 64'(t_req_ready), 64'd0);
    step(); #1;
    chk("hold.rsp3", 64'(t_rsp_valid), 64'd1);
    chk("hold.ld0", 64'(t_ld_data), 64'd0);
    t_rsp_ready = 1'b1;
    step(); #1;
    chk("hold.released", 64'(t_rsp_valid), 64'd0);
    chk("hold.idle", 64'(t_req_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
